// File: rtl/regr_pipe.sv
// regr_pipe: elastic pipeline register, DEPTH stages of N-bit data.
// Valid/ready handshake with bubble collapsing, global hold (stall),
// synchronous clear (flush) and an optional one-entry input skid buffer
// that makes in_ready a register output.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   clear                 synchronous flush of every entry
//   hold                  stall; no stage moves, out_valid forced low
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data from stage DEPTH-1
//   count                 occupied entries (stages plus skid)
module regr_pipe #(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned SKID  = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        hold,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N-1:0]                in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N-1:0]                out_data,
   output logic [$clog2(DEPTH+2)-1:0]  count
);

   localparam int unsigned CW = $clog2(DEPTH + 2);

   logic [DEPTH-1:0]         v_q;
   logic [DEPTH-1:0]         v_n;
   logic [DEPTH-1:0]         mv;
   logic [DEPTH-1:0]         ld;
   logic [DEPTH-1:0][N-1:0]  data_q;
   logic [DEPTH-1:0][N-1:0]  data_n;
   logic                     skid_v_q;
   logic                     skid_v_n;
   logic [N-1:0]             skid_data_q;
   logic [N-1:0]             skid_data_n;
   logic                     rdy_q;
   logic [CW-1:0]            count_q;
   logic [CW-1:0]            count_n;
   logic                     take;
   logic                     acc;
   logic                     src_v;
   logic [N-1:0]             src_data;

   // Handshake and move/load chain; ld ripples from the output stage back
   // to stage 0 so a bubble anywhere is filled in the same cycle.
   always_comb begin
      out_valid   = v_q[DEPTH-1] & ~hold;
      take        = out_valid & out_ready;
      mv          = '0;
      ld          = '0;
      mv[DEPTH-1] = take;
      ld[DEPTH-1] = ~hold & ~clear & (~v_q[DEPTH-1] | mv[DEPTH-1]);
      for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
         mv[k] = v_q[k] & ld[k+1];
         ld[k] = ~hold & ~clear & (~v_q[k] | mv[k]);
      end
      in_ready = (SKID != 0) ? rdy_q : ld[0];
      acc      = in_valid & in_ready;
      // A full skid has priority into stage 0; it blocks new input anyway.
      src_v    = skid_v_q | acc;
      src_data = skid_v_q ? skid_data_q : in_data;
   end

   // Next-state for stages, skid and occupancy count.
   always_comb begin
      v_n         = v_q;
      data_n      = data_q;
      skid_v_n    = skid_v_q;
      skid_data_n = skid_data_q;
      count_n     = '0;
      if (clear) begin
         v_n         = '0;
         data_n      = '0;
         skid_v_n    = 1'b0;
         skid_data_n = '0;
      end else begin
         if (ld[0]) begin
            v_n[0] = src_v;
            if (src_v) data_n[0] = src_data;
         end
         for (int k = 1; k < int'(DEPTH); k++) begin
            if (ld[k]) begin
               v_n[k] = mv[k-1];
               if (mv[k-1]) data_n[k] = data_q[k-1];
            end
         end
         if (SKID != 0) begin
            if (skid_v_q) begin
               if (ld[0]) skid_v_n = 1'b0;
            end else if (acc & ~ld[0]) begin
               skid_v_n    = 1'b1;
               skid_data_n = in_data;
            end
         end else begin
            skid_v_n    = 1'b0;
            skid_data_n = '0;
         end
      end
      for (int k = 0; k < int'(DEPTH); k++) begin
         count_n = count_n + CW'(v_n[k]);
      end
      count_n = count_n + CW'(skid_v_n);
   end

   // State registers; rdy_q mirrors the next skid state so in_ready is a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q         <= '0;
         data_q      <= '0;
         skid_v_q    <= 1'b0;
         skid_data_q <= '0;
         rdy_q       <= 1'b1;
         count_q     <= '0;
      end else begin
         v_q         <= v_n;
         data_q      <= data_n;
         skid_v_q    <= skid_v_n;
         skid_data_q <= skid_data_n;
         rdy_q       <= ~skid_v_n;
         count_q     <= count_n;
      end
   end

   assign out_data = data_q[DEPTH-1];
   assign count    = count_q;

endmodule

// File: tb/tb_regr_pipe.sv
// tb_regr_pipe: directed, table-driven bench for regr_pipe.
// Instance a: N=8, DEPTH=3, SKID=0.  Instance b: N=8, DEPTH=2, SKID=1.
module tb_regr_pipe;

   logic       clk;
   logic       reset;

   logic       a_clr, a_hld, a_iv, a_ir, a_ov, a_ordy;
   logic [7:0] a_id, a_od;
   logic [2:0] a_cnt;

   logic       b_clr, b_hld, b_iv, b_ir, b_ov, b_ordy;
   logic [7:0] b_id, b_od;
   logic [1:0] b_cnt;

   int n_chk;
   int n_pass;

   typedef struct {
      logic       clr;
      logic       hld;
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_od;
      logic [2:0] e_cnt;
      logic       chk_od;
   } vec_t;

   vec_t va[$];
   vec_t vb[$];

   regr_pipe #(.N(8), .DEPTH(3), .SKID(0)) u_a (
      .clk(clk), .reset(reset), .clear(a_clr), .hold(a_hld),
      .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
      .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od), .count(a_cnt)
   );

   regr_pipe #(.N(8), .DEPTH(2), .SKID(1)) u_b (
      .clk(clk), .reset(reset), .clear(b_clr), .hold(b_hld),
      .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
      .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od), .count(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic clr, input logic hld, input logic iv,
                               input logic [7:0] id, input logic ordy,
                               input logic e_ir, input logic e_ov,
                               input logic [7:0] e_od, input logic [2:0] e_cnt,
                               input logic zc);
      vec_t t;
      t.clr = clr;  t.hld = hld;  t.iv = iv;  t.id = id;  t.ordy = ordy;
      t.e_ir = e_ir;  t.e_ov = e_ov;  t.e_od = e_od;  t.e_cnt = e_cnt;
      t.chk_od = e_ov | zc;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic apply_a(input vec_t t, input int i);
      @(negedge clk);
      a_clr = t.clr;  a_hld = t.hld;  a_iv = t.iv;  a_id = t.id;  a_ordy = t.ordy;
      #1;
      chk($sformatf("a%0d in_ready", i), 32'(a_ir), 32'(t.e_ir));
      chk($sformatf("a%0d out_valid", i), 32'(a_ov), 32'(t.e_ov));
      chk($sformatf("a%0d count", i), 32'(a_cnt), 32'(t.e_cnt));
      if (t.chk_od) chk($sformatf("a%0d out_data", i), 32'(a_od), 32'(t.e_od));
   endtask

   task automatic apply_b(input vec_t t, input int i);
      @(negedge clk);
      b_clr = t.clr;  b_hld = t.hld;  b_iv = t.iv;  b_id = t.id;  b_ordy = t.ordy;
      #1;
      chk($sformatf("b%0d in_ready", i), 32'(b_ir), 32'(t.e_ir));
      chk($sformatf("b%0d out_valid", i), 32'(b_ov), 32'(t.e_ov));
      chk($sformatf("b%0d count", i), 32'(b_cnt), 32'(t.e_cnt));
      if (t.chk_od) chk($sformatf("b%0d out_data", i), 32'(b_od), 32'(t.e_od));
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      reset  = 1'b1;
      a_clr = 0; a_hld = 0; a_iv = 0; a_id = 0; a_ordy = 0;
      b_clr = 0; b_hld = 0; b_iv = 0; b_id = 0; b_ordy = 0;

      // ---- instance a: DEPTH=3, SKID=0 ----
      // back-to-back push, output three cycles after acceptance
      va.push_back(mk(0,0,1,8'h11,1, 1,0,8'h00,3'd0,0));
      va.push_back(mk(0,0,1,8'h22,1, 1,0,8'h00,3'd1,0));
      va.push_back(mk(0,0,1,8'h33,1, 1,0,8'h00,3'd2,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,1,8'h11,3'd3,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,1,8'h22,3'd2,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,1,8'h33,3'd1,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,0));
      // fill with out_ready low, 4th word enters as 1st leaves
      va.push_back(mk(0,0,1,8'h41,0, 1,0,8'h00,3'd0,0));
      va.push_back(mk(0,0,1,8'h42,0, 1,0,8'h00,3'd1,0));
      va.push_back(mk(0,0,1,8'h43,0, 1,0,8'h00,3'd2,0));
      va.push_back(mk(0,0,1,8'h44,0, 0,1,8'h41,3'd3,0));
      va.push_back(mk(0,0,1,8'h44,1, 1,1,8'h41,3'd3,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,1,8'h42,3'd3,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,1,8'h43,3'd2,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,1,8'h44,3'd1,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,0));
      // two entries frozen by hold for five cycles
      va.push_back(mk(0,0,1,8'h61,0, 1,0,8'h00,3'd0,0));
      va.push_back(mk(0,0,1,8'h62,0, 1,0,8'h00,3'd1,0));
      for (int k = 0; k < 5; k++) va.push_back(mk(0,1,1,8'h6F,1, 0,0,8'h00,3'd2,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd2,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,1,8'h61,3'd2,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,1,8'h62,3'd1,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,0));
      // full pipe flushed under hold with an input offered
      va.push_back(mk(0,0,1,8'h71,0, 1,0,8'h00,3'd0,0));
      va.push_back(mk(0,0,1,8'h72,0, 1,0,8'h00,3'd1,0));
      va.push_back(mk(0,0,1,8'h73,0, 1,0,8'h00,3'd2,0));
      va.push_back(mk(1,1,1,8'h7F,1, 0,0,8'h00,3'd3,0));
      va.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,1));
      va.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,0));

      // ---- instance b: DEPTH=2, SKID=1 ----
      // skid takes the third word, then drains in order
      vb.push_back(mk(0,0,1,8'hA1,0, 1,0,8'h00,3'd0,0));
      vb.push_back(mk(0,0,1,8'hA2,0, 1,0,8'h00,3'd1,0));
      vb.push_back(mk(0,0,1,8'hA3,0, 1,1,8'hA1,3'd2,0));
      vb.push_back(mk(0,0,1,8'hA4,0, 0,1,8'hA1,3'd3,0));
      vb.push_back(mk(0,0,0,8'h00,1, 0,1,8'hA1,3'd3,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,1,8'hA2,3'd2,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,1,8'hA3,3'd1,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,0));
      // full rate, simultaneous in and out keeps count
      vb.push_back(mk(0,0,1,8'hB1,1, 1,0,8'h00,3'd0,0));
      vb.push_back(mk(0,0,1,8'hB2,1, 1,0,8'h00,3'd1,0));
      vb.push_back(mk(0,0,1,8'hB3,1, 1,1,8'hB1,3'd2,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,1,8'hB2,3'd2,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,1,8'hB3,3'd1,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,0));
      // skid captures one input during hold
      vb.push_back(mk(0,0,1,8'hC1,0, 1,0,8'h00,3'd0,0));
      vb.push_back(mk(0,1,1,8'hC2,1, 1,0,8'h00,3'd1,0));
      vb.push_back(mk(0,1,1,8'hC3,1, 0,0,8'h00,3'd2,0));
      vb.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,3'd2,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,1,8'hC1,3'd2,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,1,8'hC2,3'd1,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,0));
      // input accepted in a clear cycle is dropped
      vb.push_back(mk(1,0,1,8'hD1,1, 1,0,8'h00,3'd0,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,0));
      // take completes in the clear cycle
      vb.push_back(mk(0,0,1,8'hE1,0, 1,0,8'h00,3'd0,0));
      vb.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,3'd1,0));
      vb.push_back(mk(1,0,0,8'h00,1, 1,1,8'hE1,3'd1,0));
      vb.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,3'd0,1));

      // reset state
      @(negedge clk);
      #1;
      chk("rst a in_ready", 32'(a_ir), 32'd1);
      chk("rst a out_valid", 32'(a_ov), 32'd0);
      chk("rst a out_data", 32'(a_od), 32'd0);
      chk("rst a count", 32'(a_cnt), 32'd0);
      chk("rst b in_ready", 32'(b_ir), 32'd1);
      chk("rst b out_valid", 32'(b_ov), 32'd0);
      chk("rst b out_data", 32'(b_od), 32'd0);
      chk("rst b count", 32'(b_cnt), 32'd0);
      reset = 1'b0;

      foreach (va[i]) apply_a(va[i], i);
      foreach (vb[i]) apply_b(vb[i], i);

      // asynchronous reset of a full pipe between clock edges
      @(negedge clk); a_iv = 1; a_id = 8'h81; a_ordy = 0;
      @(negedge clk); a_id = 8'h82;
      @(negedge clk); a_id = 8'h83;
      @(negedge clk); a_iv = 0;
      #1;
      chk("pre-reset a out_valid", 32'(a_ov), 32'd1);
      chk("pre-reset a out_data", 32'(a_od), 32'h81);
      chk("pre-reset a count", 32'(a_cnt), 32'd3);
      #1 reset = 1'b1;
      #1;
      chk("mid-reset a out_valid", 32'(a_ov), 32'd0);
      chk("mid-reset a count", 32'(a_cnt), 32'd0);
      chk("mid-reset a in_ready", 32'(a_ir), 32'd1);
      #1 reset = 1'b0;

      // post-reset word appears DEPTH cycles after acceptance
      @(negedge clk); a_iv = 1; a_id = 8'h5A; a_ordy = 1;
      #1 chk("post-reset a in_ready", 32'(a_ir), 32'd1);
      @(negedge clk); a_iv = 0;
      #1 chk("post-reset a ov t+1", 32'(a_ov), 32'd0);
      @(negedge clk);
      #1 chk("post-reset a ov t+2", 32'(a_ov), 32'd0);
      @(negedge clk);
      #1;
      chk("post-reset a ov t+3", 32'(a_ov), 32'd1);
      chk("post-reset a out_data", 32'(a_od), 32'h5A);
      chk("post-reset a count", 32'(a_cnt), 32'd1);
      @(negedge clk);
      #1;
      chk("post-reset a drained ov", 32'(a_ov), 32'd0);
      chk("post-reset a drained count", 32'(a_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
